// File: rtl/neda_fir_pipe.sv
// Pipelined streaming NEDA FIR: delay line, per-coefficient-bit-plane adder trees,
// then shift/add recombination with a negative-weight MSB plane. Full valid/ready backpressure.
module neda_fir_pipe #(
    parameter int                  DW    = 8,
    parameter int                  TAPS  = 8,
    parameter int                  CW    = 8,
    parameter logic [TAPS*CW-1:0]  COEFS = {8'd5, 8'd17, 8'd43, 8'd63, 8'd63, 8'd43, 8'd17, 8'd5},
    parameter int                  OW    = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] y
);

    localparam int PW = DW + $clog2(TAPS) + 1;

    logic                         en;
    logic signed [DW-1:0]         x_reg [TAPS];
    logic                         v1_reg;
    logic                         v2_reg;
    logic [CW-1:0][PW-1:0]        plane_next;
    logic [CW-1:0][PW-1:0]        plane_reg;
    logic signed [OW-1:0]         y_next;

    // The whole pipeline advances together; only a held, unconsumed result stalls it.
    assign en       = ~(out_valid & ~out_ready);
    assign in_ready = en & ~clr;

    // One adder tree per coefficient bit plane; taps whose coefficient bit is clear
    // are excluded at elaboration, so all-zero planes collapse to a constant.
    genvar gi;
    generate
        for (gi = 0; gi < CW; gi++) begin : g_plane
            logic signed [PW-1:0] acc;
            always_comb begin
                acc = '0;
                for (int t = 0; t < TAPS; t++) begin
                    if (COEFS[t*CW + gi]) begin
                        acc = acc + PW'(x_reg[t]);
                    end
                end
            end
            assign plane_next[gi] = acc;
        end
    endgenerate

    always_comb begin
        y_next = '0;
        for (int p = 0; p < CW - 1; p++) begin
            y_next = y_next + (OW'($signed(plane_reg[p])) <<< p);
        end
        y_next = y_next - (OW'($signed(plane_reg[CW-1])) <<< (CW - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < TAPS; t++) begin
                x_reg[t] <= '0;
            end
            v1_reg    <= 1'b0;
            v2_reg    <= 1'b0;
            plane_reg <= '0;
            out_valid <= 1'b0;
            y         <= '0;
        end else if (clr) begin
            // Flush: y keeps its stale value but is no longer marked valid.
            for (int t = 0; t < TAPS; t++) begin
                x_reg[t] <= '0;
            end
            v1_reg    <= 1'b0;
            v2_reg    <= 1'b0;
            out_valid <= 1'b0;
        end else if (en) begin
            if (in_valid) begin
                x_reg[0] <= $signed(in_data);
                for (int t = 1; t < TAPS; t++) begin
                    x_reg[t] <= x_reg[t-1];
                end
            end
            v1_reg    <= in_valid;
            plane_reg <= plane_next;
            v2_reg    <= v1_reg;
            y         <= y_next;
            out_valid <= v2_reg;
        end
    end

endmodule

// File: tb/tb_neda_fir_pipe.sv
// Scoreboarded bench for neda_fir_pipe: directed vectors push hand-computed results,
// a negedge monitor pops and compares on every output handshake.
module tb_neda_fir_pipe;

    localparam int DW   = 8;
    localparam int TAPS = 8;
    localparam int CW   = 8;
    localparam int OW   = 24;
    localparam int USE_MODEL = -999999;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] y;

    logic          in_valid2;
    logic          in_ready2;
    logic [DW-1:0] in_data2;
    logic          out_valid2;
    logic [OW-1:0] y2;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int hist[TAPS];
    int coef[TAPS] = '{5, 17, 43, 63, 63, 43, 17, 5};

    bit            stall_prev = 1'b0;
    logic [OW-1:0] y_prev;

    always #5 clk = ~clk;

    neda_fir_pipe #(.DW(DW), .TAPS(TAPS), .CW(CW), .OW(OW)) u_dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .y(y)
    );

    // c_0 = -128, all other taps zero: exercises the negative-weight MSB plane.
    neda_fir_pipe #(.DW(DW), .TAPS(TAPS), .CW(CW), .OW(OW),
                    .COEFS({56'h0, 8'h80})) u_dut_msb (
        .clk(clk), .rst(rst), .clr(1'b0),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(1'b1), .y(y2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    function automatic int model();
        int s = 0;
        for (int t = 0; t < TAPS; t++) s += coef[t] * hist[t];
        return s;
    endfunction

    // Called at posedge+2; drives one cycle and returns at the next posedge+2.
    task automatic step(input bit v, input int d, input bit ordy, input bit c,
                        input int hand, output bit acc);
        in_valid  = v;
        in_data   = d[DW-1:0];
        out_ready = ordy;
        clr       = c;
        #1;
        acc = v && in_ready && !rst;
        if (c) check("clr_blocks_in_ready", {31'd0, in_ready}, 32'd0);
        if (acc) begin
            for (int t = TAPS - 1; t > 0; t--) hist[t] = hist[t-1];
            hist[0] = d;
            exp_q.push_back(hand == USE_MODEL ? model() : hand);
        end
        if (c) for (int t = 0; t < TAPS; t++) hist[t] = 0;
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b1, 1'b0, USE_MODEL, a);
        check("queue_empty", exp_q.size(), 32'd0);
    endtask

    // Monitor: compares on each handshake and checks y holds while stalled.
    always @(negedge clk) begin
        if (!rst) begin
            if (stall_prev) begin
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_y", {8'd0, y}, {8'd0, y_prev});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h expected none", y);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    check("y", {8'd0, y}, {8'd0, 24'(e)});
                end
            end
        end
        stall_prev = !rst && !clr && out_valid && !out_ready;
        y_prev = y;
        if (rst || clr) exp_q.delete();
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t1[10] = '{5, 17, 43, 63, 63, 43, 17, 5, 0, 0};
        int up[8]  = '{635, 2794, 8255, 16256, 24257, 29718, 31877, 32512};
        int dn[8]  = '{31237, 26902, 15937, -128, -16193, -27158, -31493, -32768};
        bit a;
        int next;

        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        in_valid2 = 1'b0; in_data2 = '0;
        for (int t = 0; t < TAPS; t++) hist[t] = 0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_y", {8'd0, y}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #2;

        // 1: impulse response and two-edge latency
        step(1'b1, 1, 1'b1, 1'b0, t1[0], a);
        check("lat_e0_valid", {31'd0, out_valid}, 32'd0);
        step(1'b1, 0, 1'b1, 1'b0, t1[1], a);
        check("lat_e1_valid", {31'd0, out_valid}, 32'd0);
        step(1'b1, 0, 1'b1, 1'b0, t1[2], a);
        check("lat_e2_valid", {31'd0, out_valid}, 32'd1);
        check("lat_e2_y", {8'd0, y}, 32'd5);
        for (int i = 3; i < 10; i++) step(1'b1, 0, 1'b1, 1'b0, t1[i], a);
        drain(4);

        // 2: full-scale positive then negative; -32768 must appear as 24'hFF8000
        for (int i = 0; i < 8; i++) step(1'b1, 127, 1'b1, 1'b0, up[i], a);
        for (int i = 0; i < 2; i++) step(1'b1, 127, 1'b1, 1'b0, 32512, a);
        for (int i = 0; i < 8; i++) step(1'b1, -128, 1'b1, 1'b0, dn[i], a);
        for (int i = 0; i < 2; i++) step(1'b1, -128, 1'b1, 1'b0, -32768, a);
        drain(4);

        // 3: samples 1..20 with random input gaps and random backpressure
        next = 1;
        for (int i = 0; i < 400 && next <= 20; i++) begin
            step($urandom_range(0, 3) != 0, next, $urandom_range(0, 1) == 1, 1'b0, USE_MODEL, a);
            if (a) next++;
        end
        check("stream_all_sent", next, 32'd21);
        drain(10);

        // 4: clr mid-stream with results in flight; the sample offered during clr is dropped
        for (int i = 0; i < 8; i++) step(1'b1, 127, 1'b1, 1'b0, USE_MODEL, a);
        step(1'b1, 99, 1'b1, 1'b1, USE_MODEL, a);
        step(1'b1, 1, 1'b1, 1'b0, t1[0], a);
        check("in_ready_after_clr", {31'd0, a}, 32'd1);
        for (int i = 1; i < 10; i++) step(1'b1, 0, 1'b1, 1'b0, t1[i], a);
        drain(4);

        // 5: reset while a result is stalled at the output
        for (int i = 0; i < 4; i++) step(1'b1, 50, 1'b0, 1'b0, USE_MODEL, a);
        check("stalled_valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int t = 0; t < TAPS; t++) hist[t] = 0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_y", {8'd0, y}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #2;
        drain(3);

        // 6: c_0 = -128 instance: inputs 1, 3, 0 give -128, -384, 0
        in_valid2 = 1'b1; in_data2 = 8'd1;
        @(posedge clk); #2;
        in_data2 = 8'd3;
        @(posedge clk); #2;
        in_data2 = 8'd0;
        @(posedge clk); #2;
        check("msb_valid", {31'd0, out_valid2}, 32'd1);
        check("msb_y_m128", {8'd0, y2}, {8'd0, 24'hFFFF80});
        @(posedge clk); #2;
        check("msb_y_m384", {8'd0, y2}, {8'd0, 24'hFFFE80});
        @(posedge clk); #2;
        check("msb_y_zero", {8'd0, y2}, 32'd0);
        in_valid2 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
